// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared definitions for the hazard controller and the datapath.
//   fwd_sel_e  - EX operand select encoding, shared with the datapath muxes.
//   sb_slot_t  - one scoreboard slot (EX, MEM or WB). Register fields are
//                REG_AW_MAX wide; narrower builds zero-extend into them.
package pipe_pkg;

    localparam int unsigned REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rs;
        logic [REG_AW_MAX-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_AW_MAX-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } sb_slot_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master - pipeline side: drives enable, ID instruction fields, ex_redirect;
//            receives PC/IF-ID/ID-EX controls, forward selects, bypass, counters.
//   slave  - hazard controller side (mirror of master).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              enable;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_redirect;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              id_byp_a;
    logic              id_byp_b;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output enable, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_reg_write, id_mem_read, ex_redirect,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               id_byp_a, id_byp_b, stall_count, flush_count
    );

    modport slave (
        input  enable, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_reg_write, id_mem_read, ex_redirect,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               id_byp_a, id_byp_b, stall_count, flush_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// sb_match: one scoreboard compare. hit_o is high when the slot is a writer
// (valid, reg_write, non-zero dest) and its dest equals a source that is used.
//   valid_i, reg_write_i, dest_i - producer slot fields
//   r_i, use_i                   - consumer source address and its use flag
//   hit_o                        - dependency hit
module sb_match
    import pipe_pkg::*;
(
    input  logic                  valid_i,
    input  logic                  reg_write_i,
    input  logic [REG_AW_MAX-1:0] dest_i,
    input  logic [REG_AW_MAX-1:0] r_i,
    input  logic                  use_i,
    output logic                  hit_o
);

    always_comb begin
        hit_o = valid_i & reg_write_i & (dest_i != '0) & use_i & (dest_i == r_i);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and forwarding for the 5-stage pipeline.
// Keeps a shadow scoreboard of EX/MEM/WB and derives stalls, flushes, EX
// forward selects, ID write-back bypass and saturating stall/flush counters.
//   clk, rst - clock, synchronous active-high reset
//   bus      - pipe_hazard_ctrl_if.slave (ID fields in, pipeline controls out)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.slave bus
);

    sb_slot_t ex_q, mem_q, wb_q, ex_d, id_slot;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic stall, flush, bubble;
    logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
    logic fm_a_hit, fw_a_hit, fm_b_hit, fw_b_hit;
    fwd_sel_e fwd_a, fwd_b;

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = bus.id_valid;
        id_slot.rs        = REG_AW_MAX'(bus.id_rs[REG_AW-1:0]);
        id_slot.rt        = REG_AW_MAX'(bus.id_rt[REG_AW-1:0]);
        id_slot.use_rs    = bus.id_use_rs;
        id_slot.use_rt    = bus.id_use_rt;
        id_slot.dest      = REG_AW_MAX'(bus.id_dest[REG_AW-1:0]);
        id_slot.reg_write = bus.id_reg_write;
        id_slot.mem_read  = bus.id_mem_read;
    end

    // ID sources against EX / MEM / WB producers
    sb_match u_ex_rs  (.valid_i(ex_q.valid),  .reg_write_i(ex_q.reg_write),  .dest_i(ex_q.dest),  .r_i(id_slot.rs), .use_i(id_slot.use_rs), .hit_o(ex_rs_hit));
    sb_match u_ex_rt  (.valid_i(ex_q.valid),  .reg_write_i(ex_q.reg_write),  .dest_i(ex_q.dest),  .r_i(id_slot.rt), .use_i(id_slot.use_rt), .hit_o(ex_rt_hit));
    sb_match u_mem_rs (.valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .dest_i(mem_q.dest), .r_i(id_slot.rs), .use_i(id_slot.use_rs), .hit_o(mem_rs_hit));
    sb_match u_mem_rt (.valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .dest_i(mem_q.dest), .r_i(id_slot.rt), .use_i(id_slot.use_rt), .hit_o(mem_rt_hit));
    sb_match u_wb_rs  (.valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .dest_i(wb_q.dest),  .r_i(id_slot.rs), .use_i(id_slot.use_rs), .hit_o(wb_rs_hit));
    sb_match u_wb_rt  (.valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .dest_i(wb_q.dest),  .r_i(id_slot.rt), .use_i(id_slot.use_rt), .hit_o(wb_rt_hit));

    // EX sources against MEM / WB producers
    sb_match u_fm_a (.valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .dest_i(mem_q.dest), .r_i(ex_q.rs), .use_i(ex_q.use_rs), .hit_o(fm_a_hit));
    sb_match u_fw_a (.valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .dest_i(wb_q.dest),  .r_i(ex_q.rs), .use_i(ex_q.use_rs), .hit_o(fw_a_hit));
    sb_match u_fm_b (.valid_i(mem_q.valid), .reg_write_i(mem_q.reg_write), .dest_i(mem_q.dest), .r_i(ex_q.rt), .use_i(ex_q.use_rt), .hit_o(fm_b_hit));
    sb_match u_fw_b (.valid_i(wb_q.valid),  .reg_write_i(wb_q.reg_write),  .dest_i(wb_q.dest),  .r_i(ex_q.rt), .use_i(ex_q.use_rt), .hit_o(fw_b_hit));

    always_comb begin
        stall = 1'b0;
        if (bus.id_valid) begin
            if (FWD_EN) begin
                stall = (ex_rs_hit | ex_rt_hit) & ex_q.mem_read;
            end else begin
                stall = ex_rs_hit | ex_rt_hit | mem_rs_hit | mem_rt_hit;
            end
        end
        flush  = bus.ex_redirect;
        bubble = stall | flush | ~bus.id_valid;
        ex_d   = bubble ? '0 : id_slot;

        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (fm_a_hit)      fwd_a = FWD_MEM;
            else if (fw_a_hit) fwd_a = FWD_WB;
            if (fm_b_hit)      fwd_b = FWD_MEM;
            else if (fw_b_hit) fwd_b = FWD_WB;
        end

        // a stall overridden by a flush is not counted
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.enable) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write    = ~stall | flush;
    assign bus.ifid_write  = ~stall | flush;
    assign bus.ifid_flush  = flush;
    assign bus.idex_bubble = bubble;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.id_byp_a    = wb_rs_hit;
    assign bus.id_byp_b    = wb_rt_hit;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

    // WB source fields are carried for completeness but nothing downstream reads them
    logic unused_wb;
    assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt, wb_q.mem_read};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    typedef struct {
        int unsigned dut;
        logic rst, en, idv;
        logic [4:0] rs, rt;
        logic urs, urt;
        logic [4:0] dest;
        logic rw, mr, redir;
        logic pcw, ifidw, ifidf, bub;
        logic [1:0] fa, fb;
        logic ba, bb;
        logic [15:0] sc, fc;
    } vec_t;

    typedef struct packed {
        logic pcw, ifidw, ifidf, bub;
        logic [1:0] fa, fb;
        logic ba, bb;
        logic [15:0] sc, fc;
    } obs_t;

    logic clk;
    logic d_rst, d_en, d_idv, d_urs, d_urt, d_rw, d_mr, d_redir;
    logic [4:0] d_rs, d_rt, d_dest;

    int unsigned n_vec;
    int unsigned n_miss;
    vec_t tv[$];
    vec_t exp_q[$];
    obs_t obs [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: no forwarding, 1: forwarding, 2: no forwarding with 4-bit counters
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if0 ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifs ();

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u_dut0 (.clk(clk), .rst(d_rst), .bus(if0.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(d_rst), .bus(if1.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(4))  u_sat  (.clk(clk), .rst(d_rst), .bus(ifs.slave));

    assign if0.enable = d_en;   assign if1.enable = d_en;   assign ifs.enable = d_en;
    assign if0.id_valid = d_idv; assign if1.id_valid = d_idv; assign ifs.id_valid = d_idv;
    assign if0.id_rs = d_rs;    assign if1.id_rs = d_rs;    assign ifs.id_rs = d_rs;
    assign if0.id_rt = d_rt;    assign if1.id_rt = d_rt;    assign ifs.id_rt = d_rt;
    assign if0.id_use_rs = d_urs; assign if1.id_use_rs = d_urs; assign ifs.id_use_rs = d_urs;
    assign if0.id_use_rt = d_urt; assign if1.id_use_rt = d_urt; assign ifs.id_use_rt = d_urt;
    assign if0.id_dest = d_dest; assign if1.id_dest = d_dest; assign ifs.id_dest = d_dest;
    assign if0.id_reg_write = d_rw; assign if1.id_reg_write = d_rw; assign ifs.id_reg_write = d_rw;
    assign if0.id_mem_read = d_mr;  assign if1.id_mem_read = d_mr;  assign ifs.id_mem_read = d_mr;
    assign if0.ex_redirect = d_redir; assign if1.ex_redirect = d_redir; assign ifs.ex_redirect = d_redir;

    assign obs[0] = {if0.pc_write, if0.ifid_write, if0.ifid_flush, if0.idex_bubble, if0.fwd_a, if0.fwd_b,
                     if0.id_byp_a, if0.id_byp_b, if0.stall_count, if0.flush_count};
    assign obs[1] = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble, if1.fwd_a, if1.fwd_b,
                     if1.id_byp_a, if1.id_byp_b, if1.stall_count, if1.flush_count};
    assign obs[2] = {ifs.pc_write, ifs.ifid_write, ifs.ifid_flush, ifs.idex_bubble, ifs.fwd_a, ifs.fwd_b,
                     ifs.id_byp_a, ifs.id_byp_b, 12'd0, ifs.stall_count, 12'd0, ifs.flush_count};

    function automatic vec_t mk(
        input int unsigned dut, input logic rst, input logic en, input logic idv,
        input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
        input logic [4:0] dest, input logic rw, input logic mr, input logic redir,
        input logic pcw, input logic ifidf, input logic bub,
        input logic [1:0] fa, input logic [1:0] fb, input logic ba, input logic bb,
        input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.dut = dut; v.rst = rst; v.en = en; v.idv = idv;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.dest = dest; v.rw = rw; v.mr = mr; v.redir = redir;
        v.pcw = pcw; v.ifidw = pcw; v.ifidf = ifidf; v.bub = bub;
        v.fa = fa; v.fb = fb; v.ba = ba; v.bb = bb; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        d_rst = v.rst; d_en = v.en; d_idv = v.idv;
        d_rs = v.rs; d_rt = v.rt; d_urs = v.urs; d_urt = v.urt;
        d_dest = v.dest; d_rw = v.rw; d_mr = v.mr; d_redir = v.redir;
    endtask

    task automatic chk(input string nm, input int unsigned idx, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s #%0d: got %0h, want %0h", nm, idx, act, want);
        end
    endtask

    task automatic compare(input vec_t e, input int unsigned idx);
        obs_t o;
        o = obs[e.dut];
        chk("pc_write",    idx, 16'(o.pcw),   16'(e.pcw));
        chk("ifid_write",  idx, 16'(o.ifidw), 16'(e.ifidw));
        chk("ifid_flush",  idx, 16'(o.ifidf), 16'(e.ifidf));
        chk("idex_bubble", idx, 16'(o.bub),   16'(e.bub));
        chk("fwd_a",       idx, 16'(o.fa),    16'(e.fa));
        chk("fwd_b",       idx, 16'(o.fb),    16'(e.fb));
        chk("id_byp_a",    idx, 16'(o.ba),    16'(e.ba));
        chk("id_byp_b",    idx, 16'(o.bb),    16'(e.bb));
        chk("stall_count", idx, o.sc,         e.sc);
        chk("flush_count", idx, o.fc,         e.fc);
    endtask

    task automatic run_vec(input vec_t v, input int unsigned idx);
        @(negedge clk);
        apply(v);
        exp_q.push_back(v);
        #1;
        compare(exp_q.pop_front(), idx);
    endtask

    initial begin
        vec_t idle, x_ins, v;
        n_vec = 0;
        n_miss = 0;
        idle  = mk(0, 0,1, 0,0,0,0,0,0,0,0,0, 1,0,1, 0,0,0,0, 0,0);
        x_ins = mk(0, 0,1, 1,2,0,1,0,2,1,0,0, 1,0,0, 0,0,0,0, 0,0);

        // forwarding build: load-use, ALU-ALU forward, stall+redirect, $0, enable hold, reset mid-stall
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 0,0));
        tv.push_back(mk(1, 0,1, 1, 1,0,1,0, 2,1,1,0, 1,0,0, 0,0,0,0, 0,0));
        tv.push_back(mk(1, 0,1, 1, 2,4,1,1, 3,1,0,0, 0,0,1, 0,0,0,0, 0,0));
        tv.push_back(mk(1, 0,1, 1, 2,4,1,1, 3,1,0,0, 1,0,0, 0,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 2,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 1, 1,1,1,1, 5,1,0,0, 1,0,0, 0,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 1, 5,5,1,1, 6,1,0,0, 1,0,0, 0,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 1,1,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 1, 1,0,1,0, 7,1,1,0, 1,0,0, 0,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 1, 7,7,1,1, 8,1,0,1, 1,1,1, 0,0,0,0, 1,0));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,1, 1, 7,1,1,1, 0,1,0,0, 1,0,0, 0,0,1,0, 1,1));
        tv.push_back(mk(1, 0,1, 1, 0,0,1,1, 9,1,0,0, 1,0,0, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,1, 1, 1,0,1,0,10,1,1,0, 1,0,0, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,0, 1,10,0,1,0,11,1,0,0, 0,0,1, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,0, 1,10,0,1,0,11,1,0,0, 0,0,1, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,1, 1,10,0,1,0,11,1,0,0, 0,0,1, 0,0,0,0, 1,1));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 2,1));
        tv.push_back(mk(1, 0,1, 1, 1,0,1,0,12,1,1,0, 1,0,0, 0,0,0,0, 2,1));
        tv.push_back(mk(1, 1,1, 1,12,0,1,0,13,1,0,0, 0,0,1, 0,0,0,0, 2,1));
        tv.push_back(mk(1, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 0,0));
        // non-forwarding build: producer in EX costs two stalls, then ID bypass
        tv.push_back(mk(0, 0,1, 1, 1,1,1,1, 5,1,0,0, 1,0,0, 0,0,0,0, 0,0));
        tv.push_back(mk(0, 0,1, 1, 5,5,1,1, 6,1,0,0, 0,0,1, 0,0,0,0, 0,0));
        tv.push_back(mk(0, 0,1, 1, 5,5,1,1, 6,1,0,0, 0,0,1, 0,0,0,0, 1,0));
        tv.push_back(mk(0, 0,1, 1, 5,5,1,1, 6,1,0,0, 1,0,0, 0,0,1,1, 2,0));
        tv.push_back(mk(0, 0,1, 0, 0,0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0, 2,0));

        v = idle;
        v.rst = 1'b1;
        apply(v);
        repeat (2) @(posedge clk);

        foreach (tv[i]) run_vec(tv[i], i);

        // self-dependent instruction held in ID: two stalls every three cycles
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            apply(x_ins);
        end
        @(negedge clk);
        apply(idle);
        #1;
        chk("stall_count_16b", 100, obs[0].sc, 16'd22);
        chk("stall_count_sat", 101, obs[2].sc, 16'd15);

        // continuous redirect saturates the narrow flush counter
        v = idle;
        v.redir = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            apply(v);
        end
        @(negedge clk);
        apply(idle);
        #1;
        chk("flush_count_16b", 102, obs[0].fc, 16'd20);
        chk("flush_count_sat", 103, obs[2].fc, 16'd15);
        chk("stall_hold_16b",  104, obs[0].sc, 16'd22);
        chk("stall_hold_sat",  105, obs[2].sc, 16'd15);

        // reset coincident with a stall and a redirect
        @(negedge clk);
        v = x_ins;
        v.rst = 1'b1;
        v.redir = 1'b1;
        apply(v);
        @(negedge clk);
        apply(idle);
        for (int unsigned d = 0; d < 3; d++) begin
            v = idle;
            v.dut = d;
            exp_q.push_back(v);
        end
        #1;
        for (int unsigned d = 0; d < 3; d++) compare(exp_q.pop_front(), 200 + d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard-detection and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB) once the inter-stage registers become real flops. It keeps a shadow scoreboard of the instructions in EX, MEM and WB (valid, sources, destination, write and load flags). From that scoreboard it drives:
- load-use stalls,
- branch/jump flushes,
- EX-stage forwarding selects,
- ID-stage write-back bypass.

Both forwarding and non-forwarding builds are supported, and saturating stall/flush counters are included.

## Interface
- `REG_AW`, 5: register address width (`2**REG_AW` architectural registers; register 0 is hard-wired zero).
- `FWD_EN`, 1: 1 enables EX forwarding (stall only on load-use); 0 disables forwarding (stall on any EX/MEM producer match).
- `CNT_W`, 16: width of the saturating performance counters.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  pipeline advance; low freezes all state and counters.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_AW  ID source register addresses.
- `id_use_rs`, `id_use_rt`  in  1  the source is actually read.
- `id_dest`  in  REG_AW  ID destination after the reg_dst mux.
- `id_reg_write`, `id_mem_read`  in  1  ID control flags.
- `ex_redirect`  in  1  the branch/jump in EX is taken.
- `pc_write`  out  1  PC may update.
- `ifid_write`  out  1  IF/ID register may load.
- `ifid_flush`  out  1  IF/ID register loads a bubble.
- `idex_bubble`  out  1  ID/EX register loads a bubble instead of ID.
- `fwd_a`, `fwd_b`  out  2  EX operand selects: 0 = ID/EX regfile value, 1 = EX/MEM ALU result, 2 = MEM/WB write data.
- `id_byp_a`, `id_byp_b`  out  1  ID operand takes WB write data.
- `stall_count`, `flush_count`  out  CNT_W  saturating event counters.

## Operation
- Scoreboard has three slots: EX, MEM, WB. Each slot holds valid, rs, rt, use_rs, use_rt, dest, reg_write, mem_read. All slots clear on `rst`.
- A slot is a **writer** when valid & reg_write & dest != 0.
- `match(slot, r, use)` = writer(slot) & use & slot.dest == r.
- **Stall**, evaluated only when `id_valid`:
  - FWD_EN = 1: stall when match(EX, rs) or match(EX, rt) and EX.mem_read.
  - FWD_EN = 0: stall on any match against EX or MEM.
- **Flush** = `ex_redirect`. Flush has priority over stall: when both are set, no stall is taken and the stall counter does not increment.
- Outputs:
  - `pc_write = ifid_write = ~stall | flush`.
  - `ifid_flush = flush`.
  - `idex_bubble = stall | flush | ~id_valid`.
- Advance, on an edge with `enable` high:
  - WB takes MEM, MEM takes EX.
  - EX takes the ID fields, or an all-zero slot when `idex_bubble`.
- **Forwarding**, combinational from the EX slot against the MEM and WB slots:
  - `fwd_a = 1` if match(MEM, EX.rs); else 2 if match(WB, EX.rs); else 0. `fwd_b` is the same using EX.rt.
  - MEM has priority over WB.
  - When FWD_EN = 0, `fwd_a` and `fwd_b` are tied to 0.
- **ID bypass**: `id_byp_a = match(WB, id_rs)`, `id_byp_b = match(WB, id_rt)`. Active in both modes, because the register file does not write through.
- **Counters**:
  - `stall_count` increments on an enabled edge where stall & ~flush.
  - `flush_count` increments on an enabled edge where flush.
  - Both hold at `2**CNT_W - 1`.

## Timing
- Reset: all slots invalid and both counters 0. `pc_write`, `ifid_write` and `idex_bubble` are 1; `ifid_flush` is 0; `fwd_*` and `id_byp_*` are 0.
- Every output is combinational from the current state and inputs, so decisions take effect in the same cycle. Scoreboard latency is one cycle per stage.
- Load-use with FWD_EN = 1 costs exactly 1 stall cycle. The following cycle shows `fwd = 2` from WB.
- FWD_EN = 0 with a producer in EX costs 2 stall cycles. The consumer then reads the value through `id_byp`.
- Redirect kills exactly the IF and ID instructions. The EX instruction (the branch) continues.
- `enable` low: state is held and the outputs still reflect the held state.
- `rst` during a stall or flush: state clears on that edge and the counters do not increment.

## Structure
- Shared package `pipe_pkg`: `fwd_sel` encoding constants (`FWD_RF = 0`, `FWD_MEM = 1`, `FWD_WB = 2`) and the scoreboard slot struct, so the datapath muxes use the same encoding.
- One sub-module, `sb_match`: the combinational writer/address compare, instantiated per slot/source pair.

## Test plan
- FWD_EN = 1, `lw $2`, then `add $3,$2,$4` -> one cycle with `pc_write = 0` and `idex_bubble = 1`; next cycle `fwd_a = 2`; `stall_count = 1`.
- FWD_EN = 1, `add $5`, then `sub $6,$5,$5` -> no stall; `fwd_a = fwd_b = 1` in the consumer's EX cycle.
- FWD_EN = 0, same pair -> 2 stall cycles, then `id_byp_a = id_byp_b = 1`; `fwd` stays 0.
- Load-use stall coincident with `ex_redirect` -> `ifid_flush = 1`, `pc_write = 1`, `flush_count` +1, `stall_count` unchanged.
- Writer with dest = 0 followed by a reader of $0 -> no stall, `fwd = 0`, `id_byp = 0`.
- `stall_count` preloaded to saturation by 65535 stalls (CNT_W = 16) -> holds at 0xFFFF; `rst` -> all outputs at their reset values.
